// File: rtl/alu_issue_wb_if.sv
// Issue/result bus between an instruction source and the alu_issue_wb sequencer.
// The master side offers decoded instructions and observes write-back results;
// the slave side is the sequencer itself.
interface alu_issue_wb_if;
  // Instruction offer handshake and decoded fields
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_op;
  logic [1:0] in_rs;
  logic [1:0] in_rt;
  logic [1:0] in_rd;
  logic       in_use_imm;
  logic [7:0] in_imm;

  // Write-back result strobe and captured result fields
  logic       res_valid;
  logic [7:0] res_data;
  logic [1:0] res_rd;
  logic       res_zero;

  modport master (
    output in_valid,
    output in_op,
    output in_rs,
    output in_rt,
    output in_rd,
    output in_use_imm,
    output in_imm,
    input  in_ready,
    input  res_valid,
    input  res_data,
    input  res_rd,
    input  res_zero
  );

  modport slave (
    input  in_valid,
    input  in_op,
    input  in_rs,
    input  in_rt,
    input  in_rd,
    input  in_use_imm,
    input  in_imm,
    output in_ready,
    output res_valid,
    output res_data,
    output res_rd,
    output res_zero
  );
endinterface

// File: rtl/alu_issue_wb.sv
// Issue/write-back sequencer wrapped around an external 8-bit ALU.
// One instruction is accepted in IDLE, its operands are registered onto the
// ALU inputs, the ALU result is captured in EXEC, and the captured result is
// written to a private 4 x 8 register file in WB. r0 is hardwired to zero.
// The block never computes anything itself; all arithmetic lives in the ALU.
module alu_issue_wb (
  input  logic              clk,
  input  logic              rst_n,
  alu_issue_wb_if.slave     bus,
  output logic [1:0]        alu_ctl,
  output logic [7:0]        alu_a,
  output logic [7:0]        alu_b,
  input  logic [7:0]        alu_out,
  input  logic              alu_zero,
  input  logic [1:0]        dbg_rsel,
  output logic [7:0]        dbg_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_e;

  state_e          state_q,    state_d;
  logic [1:0]      alu_ctl_q,  alu_ctl_d;
  logic [7:0]      alu_a_q,    alu_a_d;
  logic [7:0]      alu_b_q,    alu_b_d;
  logic [1:0]      rd_q,       rd_d;
  logic [7:0]      res_data_q, res_data_d;
  logic [1:0]      res_rd_q,   res_rd_d;
  logic            res_zero_q, res_zero_d;
  logic [3:0][7:0] rf_q,       rf_d;

  // Register file read port: r0 always reads as zero regardless of storage.
  function automatic logic [7:0] read_reg(input logic [3:0][7:0] rf,
                                          input logic [1:0]      idx);
    return (idx == 2'd0) ? 8'h00 : rf[idx];
  endfunction

  // Next-state and datapath update: accept in IDLE, capture in EXEC, write in WB.
  always_comb begin
    state_d    = state_q;
    alu_ctl_d  = alu_ctl_q;
    alu_a_d    = alu_a_q;
    alu_b_d    = alu_b_q;
    rd_d       = rd_q;
    res_data_d = res_data_q;
    res_rd_d   = res_rd_q;
    res_zero_d = res_zero_q;
    rf_d       = rf_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          alu_ctl_d = bus.in_op;
          alu_a_d   = read_reg(rf_q, bus.in_rs);
          alu_b_d   = bus.in_use_imm ? bus.in_imm : read_reg(rf_q, bus.in_rt);
          rd_d      = bus.in_rd;
          state_d   = EXEC;
        end
      end
      EXEC: begin
        res_data_d = alu_out;
        res_zero_d = alu_zero;
        res_rd_d   = rd_q;
        state_d    = WB;
      end
      WB: begin
        if (res_rd_q != 2'd0) begin
          rf_d[res_rd_q] = res_data_q;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Keep the r0 storage cell pinned at zero so it can never hold stale data.
    rf_d[0] = 8'h00;
  end

  // State and datapath registers; reset drops any in-flight instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      alu_ctl_q  <= 2'd0;
      alu_a_q    <= 8'h00;
      alu_b_q    <= 8'h00;
      rd_q       <= 2'd0;
      res_data_q <= 8'h00;
      res_rd_q   <= 2'd0;
      res_zero_q <= 1'b0;
      rf_q       <= '0;
    end else begin
      state_q    <= state_d;
      alu_ctl_q  <= alu_ctl_d;
      alu_a_q    <= alu_a_d;
      alu_b_q    <= alu_b_d;
      rd_q       <= rd_d;
      res_data_q <= res_data_d;
      res_rd_q   <= res_rd_d;
      res_zero_q <= res_zero_d;
      rf_q       <= rf_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.res_valid = (state_q == WB);
  assign bus.res_data  = res_data_q;
  assign bus.res_rd    = res_rd_q;
  assign bus.res_zero  = res_zero_q;

  assign alu_ctl = alu_ctl_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;

  assign dbg_rdata = read_reg(rf_q, dbg_rsel);

endmodule

// File: tb/tb_alu_issue_wb.sv
// Bench for alu_issue_wb: supplies a behavioural ALU, keeps a transaction-level
// model of the sequencer, compares every cycle, and pins the model with
// hand-computed literals from directed instructions.
module tb_alu_issue_wb;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [1:0] alu_ctl;
  logic [7:0] alu_a;
  logic [7:0] alu_b;
  logic [7:0] alu_out;
  logic       alu_zero;
  logic [1:0] dbg_rsel;
  logic [7:0] dbg_rdata;

  int assertions = 0;
  int failures   = 0;

  alu_issue_wb_if bus();

  alu_issue_wb dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .alu_ctl   (alu_ctl),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_out   (alu_out),
    .alu_zero  (alu_zero),
    .dbg_rsel  (dbg_rsel),
    .dbg_rdata (dbg_rdata)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: add, sub, signed set-less-than, shift B left by A[3:0].
  function automatic logic [7:0] alu_fn(input logic [1:0] op,
                                        input logic [7:0] a,
                                        input logic [7:0] b);
    logic [7:0] r;
    case (op)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = ($signed(a) < $signed(b)) ? 8'h01 : 8'h00;
      default: r = b << a[3:0];
    endcase
    return r;
  endfunction

  assign alu_out  = alu_fn(alu_ctl, alu_a, alu_b);
  assign alu_zero = (alu_out == 8'h00);

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t",
               name, actual, expected, $time);
    end
  endtask

  // Transaction-level model: each accepted instruction is computed in full at
  // accept time, and its effects are scheduled by cycle distance from accept.
  int         cyc;
  int         acc;
  bit         have;
  logic [7:0] m_regs [4];
  logic [1:0] m_ctl;
  logic [7:0] m_a, m_b;
  logic [7:0] pend_res;
  logic       pend_zero;
  logic [1:0] pend_rd;
  logic [7:0] shown_res;
  logic       shown_zero;
  logic [1:0] shown_rd;

  function automatic logic m_ready();
    return !have || (cyc >= acc + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc = 0; acc = 0; have = 0;
      for (int i = 0; i < 4; i++) m_regs[i] = 8'h00;
      m_ctl = 2'd0; m_a = 8'h00; m_b = 8'h00;
      pend_res = 8'h00; pend_zero = 1'b0; pend_rd = 2'd0;
      shown_res = 8'h00; shown_zero = 1'b0; shown_rd = 2'd0;
    end else begin
      if (bus.in_valid && m_ready()) begin
        m_ctl     = bus.in_op;
        m_a       = m_regs[bus.in_rs];
        m_b       = bus.in_use_imm ? bus.in_imm : m_regs[bus.in_rt];
        pend_res  = alu_fn(m_ctl, m_a, m_b);
        pend_zero = (pend_res == 8'h00);
        pend_rd   = bus.in_rd;
        acc       = cyc + 1;
        have      = 1;
      end
      cyc = cyc + 1;
      if (have && cyc == acc + 1) begin
        shown_res  = pend_res;
        shown_zero = pend_zero;
        shown_rd   = pend_rd;
      end
      if (have && cyc == acc + 2 && pend_rd != 2'd0) m_regs[pend_rd] = pend_res;
    end
  end

  // Per-cycle comparison of every output against the model, away from the edge.
  always @(negedge clk) begin
    if (rst_n) begin
      checkOutput("in_ready",  bus.in_ready,  m_ready());
      checkOutput("res_valid", bus.res_valid, have && (cyc == acc + 1));
      checkOutput("alu_ctl",   alu_ctl,       m_ctl);
      checkOutput("alu_a",     alu_a,         m_a);
      checkOutput("alu_b",     alu_b,         m_b);
      checkOutput("res_data",  bus.res_data,  shown_res);
      checkOutput("res_rd",    bus.res_rd,    shown_rd);
      checkOutput("res_zero",  bus.res_zero,  shown_zero);
      checkOutput("dbg_rdata", dbg_rdata,     m_regs[dbg_rsel]);
    end
  end

  time acc_time;

  // Offer one instruction, wait (bounded) for accept and for the result strobe.
  // Returns one time unit after the edge that raises res_valid.
  task automatic applyStimulus(input logic [1:0] op, input logic [1:0] rs,
                               input logic [1:0] rt, input logic [1:0] rd,
                               input logic use_imm, input logic [7:0] imm,
                               input logic hold);
    int n;
    bus.in_valid   = 1'b1;
    bus.in_op      = op;
    bus.in_rs      = rs;
    bus.in_rt      = rt;
    bus.in_rd      = rd;
    bus.in_use_imm = use_imm;
    bus.in_imm     = imm;
    n = 0;
    while (!bus.in_ready && n < 10) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("accept_seen", bus.in_ready, 1);
    @(posedge clk);
    acc_time = $time;
    #1;
    if (!hold) bus.in_valid = 1'b0;
    n = 0;
    while (!bus.res_valid && n < 5) begin
      @(posedge clk); #1; n++;
    end
    checkOutput("res_valid_seen", bus.res_valid, 1);
    checkOutput("res_latency", n, 1);
  endtask

  task automatic waitWriteback();
    @(posedge clk); #1;
  endtask

  task automatic checkReg(input string name, input logic [1:0] idx,
                          input logic [7:0] expected);
    dbg_rsel = idx;
    #1;
    checkOutput(name, dbg_rdata, expected);
  endtask

  time t_prev;

  initial begin
    bus.in_valid = 1'b0; bus.in_op = 2'd0; bus.in_rs = 2'd0; bus.in_rt = 2'd0;
    bus.in_rd = 2'd0; bus.in_use_imm = 1'b0; bus.in_imm = 8'h00; dbg_rsel = 2'd0;

    #1 rst_n = 1'b0;
    #1;
    checkOutput("rst_in_ready",  bus.in_ready,  1);
    checkOutput("rst_res_valid", bus.res_valid, 0);
    checkOutput("rst_alu_ctl",   alu_ctl,       0);
    checkOutput("rst_alu_a",     alu_a,         0);
    checkOutput("rst_alu_b",     alu_b,         0);
    checkOutput("rst_res_data",  bus.res_data,  0);
    checkOutput("rst_res_rd",    bus.res_rd,    0);
    checkOutput("rst_res_zero",  bus.res_zero,  0);
    checkReg("rst_reg1", 2'd1, 8'h00);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] add immediate from reset");
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd1, 1'b1, 8'h05, 1'b0);
    checkOutput("t1_alu_a", alu_a, 8'h00);
    checkOutput("t1_alu_b", alu_b, 8'h05);
    checkOutput("t1_res", bus.res_data, 8'h05);
    checkOutput("t1_zero", bus.res_zero, 0);
    waitWriteback();
    checkReg("t1_reg1", 2'd1, 8'h05);

    $display("[TB] sub with wrap");
    applyStimulus(2'd1, 2'd1, 2'd0, 2'd2, 1'b1, 8'h07, 1'b0);
    checkOutput("t2_res", bus.res_data, 8'hFE);
    checkOutput("t2_zero", bus.res_zero, 0);
    waitWriteback();
    checkReg("t2_reg2", 2'd2, 8'hFE);

    applyStimulus(2'd1, 2'd1, 2'd1, 2'd3, 1'b0, 8'h00, 1'b0);
    checkOutput("t3_res", bus.res_data, 8'h00);
    checkOutput("t3_zero", bus.res_zero, 1);
    waitWriteback();

    $display("[TB] signed slt");
    applyStimulus(2'd2, 2'd2, 2'd1, 2'd3, 1'b0, 8'h00, 1'b0);
    checkOutput("t4_res", bus.res_data, 8'h01);
    waitWriteback();
    checkReg("t4_reg3", 2'd3, 8'h01);

    applyStimulus(2'd2, 2'd1, 2'd2, 2'd3, 1'b0, 8'h00, 1'b0);
    checkOutput("t5_res", bus.res_data, 8'h00);
    checkOutput("t5_zero", bus.res_zero, 1);
    waitWriteback();

    $display("[TB] shift");
    applyStimulus(2'd3, 2'd1, 2'd0, 2'd2, 1'b1, 8'h03, 1'b0);
    checkOutput("t6_res", bus.res_data, 8'h60);
    waitWriteback();
    checkReg("t6_reg2", 2'd2, 8'h60);

    $display("[TB] write to r0 and back-to-back issue");
    applyStimulus(2'd0, 2'd1, 2'd0, 2'd0, 1'b1, 8'h10, 1'b1);
    t_prev = acc_time;
    checkOutput("t7_res0", bus.res_data, 8'h15);
    checkOutput("t7_rd0", bus.res_rd, 0);
    waitWriteback();
    checkReg("t7_reg0", 2'd0, 8'h00);
    applyStimulus(2'd0, 2'd0, 2'd0, 2'd3, 1'b1, 8'h22, 1'b1);
    checkOutput("t7_gap1", 32'(acc_time - t_prev), 30);
    t_prev = acc_time;
    checkOutput("t7_r0_operand", alu_a, 8'h00);
    checkOutput("t7_res1", bus.res_data, 8'h22);
    waitWriteback();
    applyStimulus(2'd0, 2'd3, 2'd1, 2'd1, 1'b0, 8'h00, 1'b0);
    checkOutput("t7_gap2", 32'(acc_time - t_prev), 30);
    checkOutput("t7_dep_a", alu_a, 8'h22);
    checkOutput("t7_dep_b", alu_b, 8'h05);
    checkOutput("t7_res2", bus.res_data, 8'h27);
    waitWriteback();
    checkReg("t7_reg1", 2'd1, 8'h27);

    $display("[TB] reset during write-back");
    applyStimulus(2'd0, 2'd1, 2'd0, 2'd1, 1'b1, 8'h01, 1'b0);
    checkOutput("t8_res", bus.res_data, 8'h28);
    rst_n = 1'b0;
    #1;
    checkOutput("t8_res_valid", bus.res_valid, 0);
    checkOutput("t8_res_data",  bus.res_data,  0);
    checkOutput("t8_alu_ctl",   alu_ctl,       0);
    checkOutput("t8_alu_a",     alu_a,         0);
    checkOutput("t8_alu_b",     alu_b,         0);
    checkReg("t8_reg1", 2'd1, 8'h00);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t8_in_ready", bus.in_ready, 1);
    checkOutput("t8_res_valid_after", bus.res_valid, 0);
    checkReg("t8_reg1_after", 2'd1, 8'h00);

    repeat (2) @(posedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/alu_issue_wb.md
# alu_issue_wb

Multi-cycle issue/write-back sequencer that sits directly upstream and downstream of the 8-bit MIPS-style ALU. It accepts one decoded ALU instruction per handshake and reads operands from a private 4-entry x 8-bit register file. It drives the ALU's control and operand inputs from registers, captures the ALU result and zero flag, and writes the result back. It also presents each completed result on a one-cycle result strobe.

## Interface
- No parameters. Data width fixed at 8, register file fixed at 4 entries. r0 reads as 0 and ignores writes.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid  in  1  instruction offered
- in_ready  out  1  block can accept an instruction (high only in IDLE)
- in_op  in  2  ALU operation: 0 add, 1 sub, 2 signed set-less-than, 3 shift B left by A[3:0]
- in_rs  in  2  source register for operand A
- in_rt  in  2  source register for operand B when in_use_imm=0
- in_rd  in  2  destination register
- in_use_imm  in  1  1: operand B = in_imm; 0: operand B = reg[in_rt]
- in_imm  in  8  immediate operand
- alu_ctl  out  2  to ALU control input, registered
- alu_a  out  8  to ALU operand A, registered
- alu_b  out  8  to ALU operand B, registered
- alu_out  in  8  from ALU result
- alu_zero  in  1  from ALU zero flag
- res_valid  out  1  one-cycle strobe: result written
- res_data  out  8  captured result
- res_rd  out  2  destination of captured result
- res_zero  out  1  captured zero flag
- dbg_rsel  in  2  debug register select
- dbg_rdata  out  8  combinational read of reg[dbg_rsel] (0 when dbg_rsel=0)

## Operation
- State machine has three states: IDLE, EXEC, WB.
- IDLE:
  - in_ready=1.
  - On in_valid at a clock edge:
    - alu_ctl <= in_op.
    - alu_a <= reg[in_rs].
    - alu_b <= in_use_imm ? in_imm : reg[in_rt].
    - rd latch <= in_rd.
    - State -> EXEC.
  - With in_valid=0, stay in IDLE and hold all registers.
- EXEC:
  - in_ready=0.
  - ALU settles combinationally on the registered operands.
  - At the edge:
    - res_data <= alu_out.
    - res_zero <= alu_zero.
    - res_rd <= rd latch.
    - State -> WB.
- WB:
  - in_ready=0 and res_valid=1.
  - At the edge, reg[res_rd] <= res_data unless res_rd=0.
  - State -> IDLE.
- alu_ctl, alu_a and alu_b hold their values from EXEC through WB and IDLE until the next accept.
- res_data, res_rd and res_zero hold until the next EXEC capture.
- The block performs no arithmetic itself. All width, sign and shift semantics belong to the ALU: add/sub wrap mod 256, slt yields 0x01/0x00, shift uses only A[3:0].
- Operand reads in IDLE always see the write made in the preceding WB, so there are no data hazards and no forwarding.
- Instructions with in_rd=0:
  - The instruction executes normally and res_valid still pulses.
  - The register file is unchanged.
- Unused in_* fields are don't-care: in_rt when in_use_imm=1, and all fields when in_valid=0.

## Timing
- Accept edge E0 (in_valid & in_ready).
- EXEC occupies the cycle after E0; capture happens at E1.
- res_valid is high for exactly the cycle between E1 and E2; the register write happens at E2.
- in_ready returns high after E2; the earliest next accept is E3.
- Throughput: one instruction per 3 cycles. Latency from accept to res_valid: 1 cycle.
- Reset values (rst_n low, asynchronous):
  - State = IDLE.
  - in_ready = 1 once state is IDLE.
  - alu_ctl, alu_a, alu_b = 0.
  - res_valid, res_data, res_rd, res_zero = 0.
  - All registers = 0.
- Reset asserted mid-operation (EXEC or WB):
  - The in-flight instruction is dropped and no register write occurs.
  - All outputs go to reset values immediately, without waiting for a clock.
- in_valid held high continuously: a new instruction is accepted on every edge where the state is IDLE, with no bubbles beyond the 3-cycle cadence.
- in_valid during EXEC/WB is ignored. The upstream must hold the instruction until in_ready.

## Test plan
- Add with immediate, from reset:
  - Stimulus: op=0, rs=0, imm=0x05, use_imm=1, rd=1.
  - Required: alu_a=0x00, alu_b=0x05; res_valid one cycle after accept with res_data=0x05, res_zero=0; afterwards dbg reg1=0x05.
- Sub with wrap:
  - Stimulus: op=1, rs=1 (0x05), imm=0x07, rd=2.
  - Required: res_data=0xFE, res_zero=0, reg2=0xFE.
  - Stimulus: op=1, rs=1, rt=1, use_imm=0, rd=3.
  - Required: res_data=0x00, res_zero=1.
- Signed slt:
  - Stimulus: op=2, rs=2 (0xFE), rt=1 (0x05), rd=3.
  - Required: res_data=0x01.
  - Stimulus: swapped operands.
  - Required: res_data=0x00, res_zero=1.
- Shift:
  - Stimulus: op=3, rs=1 (0x05, amount 5), imm=0x03, rd=2.
  - Required: res_data=0x60, reg2=0x60.
- Write to r0 and back-to-back issue:
  - Stimulus: rd=0 instruction with in_valid held high, followed immediately by a dependent instruction reading r0 and the prior rd.
  - Required: r0 reads 0; the second instruction is accepted exactly 3 cycles after the first; the dependent operand shows the updated value.
- Reset mid-operation:
  - Stimulus: drop rst_n during WB of an instruction targeting reg1.
  - Required: res_valid=0 immediately; reg1=0; alu_* outputs=0; in_ready=1 after release.
